md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide execution unit in EX, alongside the main ALU.
- Consumes alu_function and alu_sel from ALU control; owns commands when alu_sel=1, i.e. R-type funct[4]=1.
- Performs iterative 32-cycle multiply/divide into HI/LO and services mfhi/mflo/mthi/mtlo.
- Raises stall to the pipeline while a long operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- md_valid  in  1  EX stage holds a valid instruction with alu_sel=1
- alu_function  in  5  command code {funct[5],funct[3:0]}
- op_a  in  WIDTH  rs value
- op_b  in  WIDTH  rt value
- md_result  out  WIDTH  mfhi/mflo read data (combinational)
- stall  out  1  hold pipeline; command not accepted this cycle
- busy  out  1  iterative op in progress
- done  out  1  one-cycle pulse when HI/LO are written by mult/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Command codes:
  - 5'b00000 mfhi; 5'b00001 mthi; 5'b00010 mflo; 5'b00011 mtlo
  - 5'b01000 mult; 5'b01001 multu; 5'b01010 div; 5'b01011 divu
  - All other codes are ignored: no state change, no stall.
- Reset: state=IDLE; hi=lo=0; busy=0; done=0; stall=0; md_result=0. rst mid-operation aborts the op; HI/LO go to 0.
- States: IDLE, RUN, FIX.
  - IDLE: accepts any command with md_valid=1.
  - IDLE + mult/multu/div/divu: latch operands, counter=0, go to RUN.
  - RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). After WIDTH steps go to FIX.
  - FIX: apply sign correction, write HI/LO, done=1 for one cycle, go to IDLE.
- Timing: start accepted at edge t. busy=1 for cycles t+1..t+WIDTH+1. done pulses in cycle t+WIDTH+1. New HI/LO are visible from cycle t+WIDTH+2.
- busy = (state!=IDLE).
- stall = md_valid & busy & (code is valid). A stalled command is re-presented by the pipeline and accepted in the first IDLE cycle.
- mthi/mtlo in IDLE: hi (or lo) <= op_a at the next edge; single cycle; no done pulse.
- mfhi/mflo in IDLE: md_result = hi (or lo) combinationally in the same cycle. md_result=0 for all other codes.
- Signed ops: operate on magnitudes.
  - Product sign = sign_a ^ sign_b; 2*WIDTH-bit two's-complement negate in FIX.
  - Quotient sign = sign_a ^ sign_b; remainder sign follows the dividend.
- Results:
  - mult/multu: hi = upper WIDTH bits of product, lo = lower WIDTH bits.
  - div/divu: lo = quotient, hi = remainder.
- Divide by zero (div or divu): lo = all ones, hi = op_a. Still takes full latency.
- div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, no trap.
- Simultaneous events:
  - mthi/mtlo while busy is stalled; it never corrupts the in-flight result.
  - md_valid deasserting while busy does not cancel the op.

Decomposition:
- Shared defines header holds the md command codes (MD_MFHI..MD_DIVU) alongside the existing ALUOP_* and ALU function codes, so ALU control and md_unit share one source.
- One sub-module, md_iter: combinational single step. Inputs: partial accumulator, shifted operand, mode (mul/div). Outputs: next accumulator and next quotient/product bits.
- FSM, counter, HI/LO and sign fix stay in md_unit.

Test Plan:
- mult op_a=7, op_b=0xFFFFFFFD -> done at t+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=1 exactly cycles t+1..t+33.
- multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100/7 -> lo=14, hi=2.
- divu by 0 with op_a=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
- mfhi issued one cycle after mult -> stall=1 until IDLE; then md_result = new hi in the same cycle stall drops. mthi 0xAAAA5555 while busy -> stalled, then hi=0xAAAA5555 after acceptance.
- rst asserted at iteration 10 of div -> next cycle busy=0, hi=lo=0, no done pulse. A following mtlo 5 -> lo=5.

Source files
------------

// File: rtl/md_pkg.sv
// Shared command codes and types for the multiply/divide unit.
// ALU control decodes these codes, and md_unit uses the same definitions.
package md_pkg;

  // Command codes are {funct[5], funct[3:0]} of R-type instructions with funct[4]=1.
  localparam logic [4:0] MD_MFHI  = 5'b00000;
  localparam logic [4:0] MD_MTHI  = 5'b00001;
  localparam logic [4:0] MD_MFLO  = 5'b00010;
  localparam logic [4:0] MD_MTLO  = 5'b00011;
  localparam logic [4:0] MD_MULT  = 5'b01000;
  localparam logic [4:0] MD_MULTU = 5'b01001;
  localparam logic [4:0] MD_DIV   = 5'b01010;
  localparam logic [4:0] MD_DIVU  = 5'b01011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_t;

  // True for the eight codes the unit acts on. Every other code is ignored.
  function automatic logic md_code_valid(input logic [4:0] code);
    return (code[4:2] == 3'b000) || (code[4:2] == 3'b010);
  endfunction

endpackage

// File: rtl/md_iter.sv
// One radix-2 step of the iterative multiply or divide.
// Multiply: shift-add. {acc, mq} holds the partial product and the multiplier.
// Divide: restoring shift-subtract. acc holds the remainder and mq holds the
// dividend bits, which are replaced by quotient bits as the step shifts them in.
module md_iter
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  input  md_mode_t         mode,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Compute a single step. In divide mode, diff[WIDTH] acts as the borrow flag.
  always_comb begin
    sum      = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted  = {acc, mq[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = acc;
    mq_next  = mq;
    if (mode == MODE_MUL) begin
      acc_next = sum[WIDTH:1];
      mq_next  = {sum[0], mq[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_next = diff[WIDTH-1:0];
      mq_next  = {mq[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = shifted[WIDTH-1:0];
      mq_next  = {mq[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers, used in the EX stage.
// Handshake: a command is presented with md_valid and is accepted on any edge
// where stall=0. While stall=1, the pipeline holds the command and presents it
// again. mult/multu/div/divu take WIDTH RUN cycles plus one FIX cycle.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_valid,
  input  logic [4:0]       alu_function,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] md_result,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_t        state, state_next;
  md_mode_t         mode;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mq, opnd, a_raw;
  logic [WIDTH-1:0] acc_next, mq_next;
  logic             neg_q, neg_r, div_zero;
  logic             code_valid, is_long, is_signed, start;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem;

  assign code_valid = md_code_valid(alu_function);
  assign is_long    = (alu_function[4:2] == 3'b010);
  assign is_signed  = ~alu_function[0];
  assign busy       = (state != MD_IDLE);
  assign stall      = md_valid & busy & code_valid;
  assign done       = (state == MD_FIX);
  assign start      = md_valid & (state == MD_IDLE) & is_long;
  assign mag_a      = (is_signed & op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b      = (is_signed & op_b[WIDTH-1]) ? -op_b : op_b;

  md_iter #(.WIDTH(WIDTH)) u_iter (
    .acc      (acc),
    .mq       (mq),
    .opnd     (opnd),
    .mode     (mode),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> FIX after WIDTH steps, FIX -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_RUN;
      MD_RUN:  if (cnt == LAST) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // mfhi/mflo read port. It is valid only while IDLE. A stalled read returns 0.
  always_comb begin
    md_result = '0;
    if (md_valid && state == MD_IDLE) begin
      if (alu_function == MD_MFHI)      md_result = hi;
      else if (alu_function == MD_MFLO) md_result = lo;
    end
  end

  // Sign correction of the raw magnitude results, applied in FIX.
  always_comb begin
    prod = {acc, mq};
    if (neg_q) prod = -prod;
    quot = neg_q ? -mq : mq;
    rem  = neg_r ? -acc : acc;
  end

  // Datapath: operand latch, iteration, counter and HI/LO writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      mode     <= MODE_MUL;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            cnt      <= '0;
            acc      <= '0;
            mq       <= mag_a;
            opnd     <= mag_b;
            a_raw    <= op_a;
            mode     <= alu_function[1] ? MODE_DIV : MODE_MUL;
            neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r    <= is_signed & op_a[WIDTH-1];
            div_zero <= (op_b == '0);
          end else if (md_valid && alu_function == MD_MTHI) begin
            hi <= op_a;
          end else if (md_valid && alu_function == MD_MTLO) begin
            lo <= op_a;
          end
        end
        MD_RUN: begin
          acc <= acc_next;
          mq  <= mq_next;
          cnt <= cnt + CW'(1);
        end
        MD_FIX: begin
          if (mode == MODE_MUL) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit. Expected values are hand-computed constants.
module tb_md_unit;

  localparam logic [4:0] C_MFHI  = 5'b00000;
  localparam logic [4:0] C_MTHI  = 5'b00001;
  localparam logic [4:0] C_MFLO  = 5'b00010;
  localparam logic [4:0] C_MTLO  = 5'b00011;
  localparam logic [4:0] C_MULT  = 5'b01000;
  localparam logic [4:0] C_MULTU = 5'b01001;
  localparam logic [4:0] C_DIV   = 5'b01010;
  localparam logic [4:0] C_DIVU  = 5'b01011;
  localparam logic [4:0] C_OTHER = 5'b00100;

  logic        clk, rst, md_valid;
  logic [4:0]  alu_function;
  logic [31:0] op_a, op_b, md_result, hi, lo;
  logic        stall, busy, done;

  int tests_run    = 0;
  int tests_failed = 0;

  md_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .md_valid     (md_valid),
    .alu_function (alu_function),
    .op_a         (op_a),
    .op_b         (op_b),
    .md_result    (md_result),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    md_valid = 1'b0; alu_function = 5'd0; op_a = 32'd0; op_b = 32'd0;
  endtask

  // Present a single-cycle IDLE command. Returns in the cycle after acceptance.
  task automatic drive_cmd(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    md_valid = 1'b1; alu_function = code; op_a = a; op_b = b;
    tick();
    idle_inputs();
  endtask

  // Watch a long op for a bounded number of cycles. Index 1 is cycle t+1.
  task automatic watch_op(output int done_at, output int done_cnt, output int busy_cnt,
                          output int first_busy, output int last_busy);
    done_at = -1; done_cnt = 0; busy_cnt = 0; first_busy = -1; last_busy = -1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
        last_busy = i;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      tick();
    end
  endtask

  task automatic run_long(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                          output int done_at);
    int dc, bc, fb, lb;
    drive_cmd(code, a, b);
    watch_op(done_at, dc, bc, fb, lb);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    tick(); tick();
    rst = 1'b0;
    md_valid = 1'b1; alu_function = C_MFHI;
    @(negedge clk);
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    tests_run++; if ({busy, done, stall} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got busy/done/stall=%b expected 000", {busy, done, stall}); end
    tests_run++; if (md_result !== 32'd0) begin tests_failed++; $display("FAIL reset_mfhi: got %h expected 00000000", md_result); end
    tick();
    idle_inputs();
  endtask

  task automatic test_mult_signed();
    int da, dc, bc, fb, lb;
    drive_cmd(C_MULT, 32'd7, 32'hFFFF_FFFD);
    watch_op(da, dc, bc, fb, lb);
    tests_run++; if (da !== 33) begin tests_failed++; $display("FAIL mult_done_cycle: got %0d expected 33", da); end
    tests_run++; if (dc !== 1) begin tests_failed++; $display("FAIL mult_done_count: got %0d expected 1", dc); end
    tests_run++; if (fb !== 1 || lb !== 33 || bc !== 33) begin tests_failed++; $display("FAIL mult_busy_window: got first=%0d last=%0d count=%0d expected 1 33 33", fb, lb, bc); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    tests_run++; if (lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
  endtask

  task automatic test_multu();
    int da;
    run_long(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, da);
    tests_run++; if (hi !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    tests_run++; if (lo !== 32'h0000_0001) begin tests_failed++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
  endtask

  task automatic test_div_signed();
    int da;
    run_long(C_DIV, 32'hFFFF_FFF9, 32'd2, da);
    tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    run_long(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, da);
    tests_run++; if (lo !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    tests_run++; if (hi !== 32'h0000_0000) begin tests_failed++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_divu_and_mflo();
    int da;
    run_long(C_DIVU, 32'd100, 32'd7, da);
    tests_run++; if (da !== 33) begin tests_failed++; $display("FAIL divu_done_cycle: got %0d expected 33", da); end
    tests_run++; if (lo !== 32'd14) begin tests_failed++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    tests_run++; if (hi !== 32'd2) begin tests_failed++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    md_valid = 1'b1; alu_function = C_MFLO;
    @(negedge clk);
    tests_run++; if (md_result !== 32'd14) begin tests_failed++; $display("FAIL mflo_read: got %h expected 0000000e", md_result); end
    tick();
    idle_inputs();
  endtask

  task automatic test_div_zero();
    int da;
    run_long(C_DIVU, 32'h0000_1234, 32'd0, da);
    tests_run++; if (da !== 33) begin tests_failed++; $display("FAIL divz_done_cycle: got %0d expected 33", da); end
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divuz_lo: got %h expected ffffffff", lo); end
    tests_run++; if (hi !== 32'h0000_1234) begin tests_failed++; $display("FAIL divuz_hi: got %h expected 00001234", hi); end
    run_long(C_DIV, 32'hFFFF_FFFB, 32'd0, da);
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFFB) begin tests_failed++; $display("FAIL divz_hi: got %h expected fffffffb", hi); end
  endtask

  task automatic test_mfhi_stall();
    int stall_cnt, drop_at;
    logic [31:0] res_at_drop;
    stall_cnt = 0; drop_at = -1; res_at_drop = 32'hDEAD_BEEF;
    drive_cmd(C_MULTU, 32'h0001_0000, 32'h0003_0000);
    md_valid = 1'b1; alu_function = C_MFHI;
    for (int i = 1; i <= 45 && drop_at < 0; i++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      else begin drop_at = i; res_at_drop = md_result; end
      tick();
    end
    idle_inputs();
    tests_run++; if (stall_cnt !== 33 || drop_at !== 34) begin tests_failed++; $display("FAIL mfhi_stall_len: got stall=%0d drop=%0d expected 33 34", stall_cnt, drop_at); end
    tests_run++; if (res_at_drop !== 32'd3) begin tests_failed++; $display("FAIL mfhi_after_stall: got %h expected 00000003", res_at_drop); end
  endtask

  task automatic test_mthi_stall();
    int stall_cnt, dropped;
    stall_cnt = 0; dropped = 0;
    drive_cmd(C_MULT, 32'd7, 32'hFFFF_FFFD);
    md_valid = 1'b1; alu_function = C_MTHI; op_a = 32'hAAAA_5555;
    for (int i = 1; i <= 45 && dropped == 0; i++) begin
      @(negedge clk);
      if (stall) stall_cnt++; else dropped = 1;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    tests_run++; if (stall_cnt !== 33) begin tests_failed++; $display("FAIL mthi_stall_len: got %0d expected 33", stall_cnt); end
    tests_run++; if (hi !== 32'hAAAA_5555) begin tests_failed++; $display("FAIL mthi_hi: got %h expected aaaa5555", hi); end
    tests_run++; if (lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mthi_lo_kept: got %h expected ffffffeb", lo); end
    tick();
  endtask

  task automatic test_ignored();
    logic s_busy, s_idle;
    logic [31:0] r_idle;
    md_valid = 1'b1; alu_function = C_OTHER; op_a = 32'h0000_DEAD; op_b = 32'd1;
    @(negedge clk);
    s_idle = stall; r_idle = md_result;
    tick();
    idle_inputs();
    @(negedge clk);
    tests_run++; if ({s_idle, busy} !== 2'b00) begin tests_failed++; $display("FAIL ignored_idle: got stall/busy=%b expected 00", {s_idle, busy}); end
    tests_run++; if (r_idle !== 32'd0) begin tests_failed++; $display("FAIL ignored_result: got %h expected 00000000", r_idle); end
    tests_run++; if (hi !== 32'hAAAA_5555 || lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL ignored_hilo: got %h %h expected aaaa5555 ffffffeb", hi, lo); end
    tick();
    drive_cmd(C_MULTU, 32'd2, 32'd3);
    md_valid = 1'b1; alu_function = C_OTHER;
    @(negedge clk);
    s_busy = stall;
    tests_run++; if (s_busy !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL ignored_busy: got stall=%b busy=%b expected 0 1", s_busy, busy); end
    tick();
    idle_inputs();
    for (int i = 0; i < 40; i++) tick();
    tests_run++; if (lo !== 32'd6 || hi !== 32'd0) begin tests_failed++; $display("FAIL multu_small: got %h %h expected 00000000 00000006", hi, lo); end
  endtask

  task automatic test_reset_mid_op();
    int dc;
    dc = 0;
    drive_cmd(C_DIVU, 32'd1000, 32'd3);
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    tests_run++; if (hi !== 32'd0 || lo !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_hilo: got %h %h expected 0 0", hi, lo); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dc++;
      tick();
    end
    tests_run++; if (dc !== 0) begin tests_failed++; $display("FAIL rst_mid_done: got %0d pulses expected 0", dc); end
    drive_cmd(C_MTLO, 32'd5, 32'd0);
    @(negedge clk);
    tests_run++; if (lo !== 32'd5) begin tests_failed++; $display("FAIL mtlo_after_rst: got %h expected 00000005", lo); end
    tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mtlo_flags: got done=%b busy=%b expected 0 0", done, busy); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_mult_signed();
    test_multu();
    test_div_signed();
    test_divu_and_mflo();
    test_div_zero();
    test_mfhi_stall();
    test_mthi_stall();
    test_ignored();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
